seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment BCD scan controller.
// Lights one digit at a time for ON_CYCLES clocks, with a one-cycle blank gap
// between digits to avoid ghosting. Display updates are double-buffered and
// only swap in at a frame boundary, so a frame never mixes old and new values.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | scanning stopped; all anodes off; pending value copied at once
// S_GAP  | one blank cycle before the current digit lights
// S_ON   | current digit lit; counter runs 0..ON_CYCLES-1
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int ON_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  blank_lz,
  input  logic                  upd_valid,
  input  logic [4*DIGITS-1:0]   upd_data,
  output logic                  upd_ready,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(ON_CYCLES);
  localparam logic [IW-1:0] LAST_DIG = IW'(DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ON_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_ON} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        dig_q, dig_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  display_q, display_d;
  logic [4*DIGITS-1:0]  pending_q, pending_d;
  logic                 full_q, full_d;
  logic                 frame_end;
  logic [3:0]           nibble;
  logic                 nz_upper;
  logic                 blank;
  logic [6:0]           dec;

  // State, position and buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      dig_q     <= '0;
      cnt_q     <= '0;
      display_q <= '0;
      pending_q <= '0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      display_q <= display_d;
      pending_q <= pending_d;
      full_q    <= full_d;
    end
  end

  // Scan sequencing; frame_end marks a completed frame (not an en-drop exit).
  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_GAP;
          dig_d   = '0;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (!en) begin
          state_d = S_IDLE;
          dig_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        if (!en) begin
          state_d = S_IDLE;
          dig_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_GAP;
          cnt_d   = '0;
          if (dig_q == LAST_DIG) begin
            dig_d     = '0;
            frame_end = 1'b1;
          end else begin
            dig_d = dig_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        dig_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Double buffer: swap at frame end (or immediately while idle), then capture.
  always_comb begin
    display_d = display_q;
    pending_d = pending_q;
    full_d    = full_q;
    if (full_q && (state_q == S_IDLE || frame_end)) begin
      display_d = pending_q;
      full_d    = 1'b0;
    end
    if (upd_valid && !full_q) begin
      pending_d = upd_data;
      full_d    = 1'b1;
    end
  end

  // Select the lit nibble and find whether it and all higher nibbles are zero.
  always_comb begin
    nibble   = 4'd0;
    nz_upper = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == dig_q) nibble = display_q[4*i +: 4];
      if (IW'(i) >= dig_q && display_q[4*i +: 4] != 4'd0) nz_upper = 1'b1;
    end
    blank = blank_lz && (dig_q != '0) && !nz_upper;
  end

  // BCD to segments a..g; non-decimal codes are dark.
  always_comb begin
    case (nibble)
      4'd0:    dec = 7'b1111110;
      4'd1:    dec = 7'b0110000;
      4'd2:    dec = 7'b1101101;
      4'd3:    dec = 7'b1111001;
      4'd4:    dec = 7'b0110011;
      4'd5:    dec = 7'b1011011;
      4'd6:    dec = 7'b1011111;
      4'd7:    dec = 7'b1110000;
      4'd8:    dec = 7'b1111111;
      4'd9:    dec = 7'b1111011;
      default: dec = 7'b0000000;
    endcase
  end

  // Moore outputs from registered state; only blank_lz reaches seg directly.
  always_comb begin
    an  = '0;
    seg = 7'b0000000;
    if (state_q == S_ON) begin
      an[dig_q] = 1'b1;
      seg       = blank ? 7'b0000000 : dec;
    end
    frame_done = (state_q == S_ON) && (dig_q == LAST_DIG) && (cnt_q == LAST_CNT);
    upd_ready  = !full_q;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios then random traffic, every cycle
// compared against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int ONC    = 4;
  localparam int SLOT   = ONC + 1;
  localparam int FRAME  = DIGITS * SLOT;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                en = 1'b0;
  logic                blank_lz = 1'b0;
  logic                upd_valid = 1'b0;
  logic [4*DIGITS-1:0] upd_data = '0;
  logic                upd_ready;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                frame_done;

  int checks = 0;
  int errors = 0;

  // reference model: running flag, position within the frame, buffers
  bit                  m_run;
  int                  m_pos;
  logic [4*DIGITS-1:0] m_disp, m_pend;
  bit                  m_full;

  seg_scan_ctrl #(.DIGITS(DIGITS), .ON_CYCLES(ONC)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .blank_lz(blank_lz),
    .upd_valid(upd_valid), .upd_data(upd_data), .upd_ready(upd_ready),
    .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_run = 0; m_pos = 0; m_disp = '0; m_pend = '0; m_full = 0;
  endtask

  task automatic check_outputs();
    int d, ph;
    logic [DIGITS-1:0] e_an;
    logic [6:0]        e_seg;
    logic              e_fd;
    e_an = '0; e_seg = '0; e_fd = 1'b0;
    d  = m_pos / SLOT;
    ph = m_pos % SLOT;
    if (m_run && ph != 0) begin
      e_an[d] = 1'b1;
      if (blank_lz && d > 0 && (m_disp >> (4*d)) == 0) e_seg = '0;
      else e_seg = seg_of(m_disp[4*d +: 4]);
    end
    e_fd = m_run && (m_pos == FRAME - 1);
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("upd_ready", 32'(upd_ready), 32'(!m_full));
  endtask

  task automatic model_edge();
    bit was_run, was_full, fend;
    was_run  = m_run;
    was_full = m_full;
    fend     = m_run && (m_pos == FRAME - 1) && en;
    if (m_run) begin
      if (!en) begin m_run = 0; m_pos = 0; end
      else m_pos = (m_pos + 1) % FRAME;
    end else if (en) begin
      m_run = 1; m_pos = 0;
    end
    if (was_full && (!was_run || fend)) begin
      m_disp = m_pend; m_full = 0;
    end
    if (upd_valid && !was_full) begin
      m_pend = upd_data; m_full = 1;
    end
  endtask

  // Check this cycle, clock, advance model; returns at the next falling edge.
  task automatic tick();
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (!(m_run && m_pos == target) && n < 4*FRAME) begin
      tick();
      n++;
    end
    chk("run_to_reached", 32'(m_run && m_pos == target), 32'd1);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 m_reset();
    check_outputs();
    chk("rst_an", 32'(an), 32'd0);
    chk("rst_ready", 32'(upd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
    tick();

    // leading-zero blanking with 0x0042 loaded while idle
    blank_lz = 1'b1; upd_valid = 1'b1; upd_data = 16'h0042;
    tick();
    upd_valid = 1'b0; upd_data = 16'hFFFF;
    tick();
    en = 1'b1;
    run_to(1);
    chk("lz_d0", 32'(seg), 32'(7'b1101101));
    run_to(SLOT + 1);
    chk("lz_d1", 32'(seg), 32'(7'b0110011));
    run_to(2*SLOT + 1);
    chk("lz_d2_an", 32'(an), 32'(4'b0100));
    chk("lz_d2_seg", 32'(seg), 32'd0);
    run_to(3*SLOT + 1);
    chk("lz_d3_seg", 32'(seg), 32'd0);
    run_to(FRAME - 1);
    tick();

    // basic scan after reset, blanking off
    en = 1'b0; blank_lz = 1'b0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 2*FRAME + 2; i++) tick();

    // update mid-frame, second request held until the swap frees the buffer
    run_to(4);
    upd_valid = 1'b1; upd_data = 16'h1234;
    tick();
    chk("upd_busy", 32'(upd_ready), 32'd0);
    upd_data = 16'h5678;
    run_to(FRAME - 1);
    tick();
    tick();
    chk("new_d0", 32'(seg), 32'(7'b0110011));
    run_to(3*SLOT + 1);
    chk("new_d3", 32'(seg), 32'(7'b0110000));
    upd_valid = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) tick();

    // non-BCD nibble on digit 2
    upd_valid = 1'b1; upd_data = 16'h0A00;
    tick();
    upd_valid = 1'b0;
    run_to(FRAME - 1);
    tick();
    run_to(2*SLOT + 1);
    chk("hex_an", 32'(an), 32'(4'b0100));
    chk("hex_seg", 32'(seg), 32'd0);

    // drop en during digit 2, then restart
    tick();
    en = 1'b0;
    tick();
    chk("drop_an", 32'(an), 32'd0);
    chk("drop_fd", 32'(frame_done), 32'd0);
    tick(); tick();
    en = 1'b1;
    tick();
    chk("restart_gap", 32'(an), 32'd0);
    tick();
    chk("restart_d0", 32'(an), 32'(4'b0001));
    for (int i = 0; i < 8; i++) tick();

    // reset with an update pending
    upd_valid = 1'b1; upd_data = 16'h9999;
    tick();
    upd_valid = 1'b0;
    chk("pend_full", 32'(upd_ready), 32'd0);
    do_reset();
    tick();
    tick();
    chk("post_rst_seg", 32'(seg), 32'(7'b1111110));

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      en        = ($urandom_range(0, 99) < 97);
      upd_valid = ($urandom_range(0, 99) < 12);
      upd_data  = 16'($urandom);
      if ($urandom_range(0, 99) < 4) blank_lz = ~blank_lz;
      if ($urandom_range(0, 999) < 3) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
